// File: rtl/elevator_call_scheduler.sv
// Single-car SCAN call scheduler: latches calls, sequences travel and door dwell, honours hold/lock.
// Optional idle homing to floor 0 is built when ELEVATOR_SCHED_HOMING_EN is defined.
module elevator_call_scheduler #(
    parameter int FLOORS           = 4,
    parameter int FLOOR_W          = 2,
    parameter int TRAVEL_CYCLES    = 16,
    parameter int DOOR_CYCLES      = 8,
    parameter int IDLE_HOME_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  call_req,
    input  logic               hold,
    input  logic               lock,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic               arrive,
    output logic [FLOORS-1:0]  pending,
    output logic               locked
);
    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_LOCKED} state_t;

    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t               state_q, state_d;
    logic [FLOOR_W-1:0]   cur_floor_q, cur_floor_d;
    logic                 dir_up_q, dir_up_d;
    logic [FLOORS-1:0]    pending_q, pending_d;
    logic                 arrive_q, arrive_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FLOOR_W-1:0]   next_floor;
    logic [FLOORS-1:0]    target;
    logic                 ahead, behind, ahead_next;

`ifdef ELEVATOR_SCHED_HOMING_EN
    localparam int IDLE_W = $clog2(IDLE_HOME_CYCLES + 1);
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                 homing_q, homing_d;
    logic                 home_ok;
`endif

    // True when any floor set in pend lies strictly beyond fl in the given direction.
    function automatic logic any_beyond(input logic [FLOORS-1:0] pend,
                                        input logic [FLOOR_W-1:0] fl,
                                        input logic up);
        logic r;
        r = 1'b0;
        for (int f = 0; f < FLOORS; f++) begin
            if (pend[f] && (up ? (f > int'(fl)) : (f < int'(fl))))
                r = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        dir_up_d    = dir_up_q;
        cnt_d       = cnt_q;
        arrive_d    = 1'b0;
        next_floor  = dir_up_q ? cur_floor_q + FLOOR_W'(1) : cur_floor_q - FLOOR_W'(1);
        target      = pending_q;
`ifdef ELEVATOR_SCHED_HOMING_EN
        homing_d    = homing_q;
        home_ok     = (pending_q == '0) && !lock && (cur_floor_q != '0);
        idle_cnt_d  = (state_q == S_IDLE && home_ok) ? idle_cnt_q + IDLE_W'(1) : '0;
        // While homing with no real calls, floor 0 acts as the only target.
        if (homing_q && pending_q == '0)
            target[0] = 1'b1;
`endif
        ahead      = any_beyond(target, cur_floor_q, dir_up_q);
        behind     = any_beyond(target, cur_floor_q, !dir_up_q);
        ahead_next = any_beyond(target, next_floor, dir_up_q);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (lock)
                    state_d = S_LOCKED;
                else if (pending_q[cur_floor_q])
                    state_d = S_DOOR;
                else if (ahead)
                    state_d = S_MOVE;
                else if (behind) begin
                    state_d  = S_MOVE;
                    dir_up_d = !dir_up_q;
                end
`ifdef ELEVATOR_SCHED_HOMING_EN
                else if (home_ok && idle_cnt_q == IDLE_W'(IDLE_HOME_CYCLES - 1)) begin
                    state_d  = S_MOVE;
                    dir_up_d = 1'b0;
                    homing_d = 1'b1;
                end
`endif
            end
            S_MOVE: begin
                if (cnt_q == CNT_W'(TRAVEL_CYCLES - 1)) begin
                    cnt_d       = '0;
                    cur_floor_d = next_floor;
                    arrive_d    = 1'b1;
                    if (target[next_floor])
                        state_d = S_DOOR;
                    else if (lock)
                        state_d = S_LOCKED;
                    else if (ahead_next)
                        state_d = S_MOVE;
                    else
                        state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DOOR: begin
                if (!hold) begin
                    if (cnt_q == CNT_W'(DOOR_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = lock ? S_LOCKED : S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_d = '0;
                if (!lock)
                    state_d = S_IDLE;
            end
        endcase

`ifdef ELEVATOR_SCHED_HOMING_EN
        // Homing ends on arrival or as soon as a real call shows up.
        if (state_d != S_MOVE || pending_q != '0)
            homing_d = 1'b0;
`endif

        // Calls for the floor being served are absorbed while the door is (or becomes) open.
        pending_d = pending_q | call_req;
        if (state_d == S_DOOR || state_q == S_DOOR)
            pending_d[cur_floor_d] = 1'b0;
        if (state_q == S_LOCKED || lock)
            pending_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_floor_q <= '0;
            dir_up_q    <= 1'b1;
            pending_q   <= '0;
            arrive_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            dir_up_q    <= dir_up_d;
            pending_q   <= pending_d;
            arrive_q    <= arrive_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef ELEVATOR_SCHED_HOMING_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
            homing_q   <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            homing_q   <= homing_d;
        end
    end
`endif

    assign cur_floor = cur_floor_q;
    assign dir_up    = dir_up_q;
    assign pending   = pending_q;
    assign arrive    = arrive_q;
    assign moving    = (state_q == S_MOVE);
    assign door_open = (state_q == S_DOOR);
    assign locked    = (state_q == S_LOCKED);
endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

Multi-floor call scheduler and sequencer for a single elevator car. It latches floor call requests, chooses the travel direction using a SCAN (collective) policy, times floor-to-floor travel and door dwell, and honours hold and lock controls. It sits between the hall/car call buttons and the car drive and door actuators.

## Interface
- FLOORS, 4, number of floors; must be ≥ 2
- FLOOR_W, 2, width of floor index; must be ≥ clog2(FLOORS)
- TRAVEL_CYCLES, 16, clock cycles to travel one floor; must be ≥ 1
- DOOR_CYCLES, 8, door dwell in clock cycles; must be ≥ 1
- IDLE_HOME_CYCLES, 64, idle cycles before homing (used only with the macro); must be ≥ 1
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high reset
- call_req  in  FLOORS  per-floor call pulses; any high bit latches that call
- hold  in  1  keeps the door open while in DOOR
- lock  in  1  takes the car out of service
- cur_floor  out  FLOOR_W  current floor index
- dir_up  out  1  current or last travel direction (1 = up)
- moving  out  1  high while in MOVE
- door_open  out  1  high while in DOOR
- arrive  out  1  one-cycle pulse each time the car reaches a floor
- pending  out  FLOORS  latched outstanding calls
- locked  out  1  high while in LOCKED

## Operation
- States: IDLE, MOVE, DOOR, LOCKED. Reset enters IDLE.
- Reset values: cur_floor=0, dir_up=1, pending=0, and every other output 0.
- Call latching:
  - Each edge, pending |= call_req, except when the state is LOCKED or lock=1; then pending is cleared to 0.
  - Bit cur_floor is forced to 0 on DOOR entry and for every cycle in DOOR.
- Direction policy, evaluated against the registered pending:
  - "ahead" means any pending floor strictly beyond cur_floor in direction dir_up.
  - "behind" means any pending floor in the opposite direction.
- IDLE, with priority top to bottom:
  - lock → LOCKED.
  - pending[cur_floor] → DOOR.
  - ahead → MOVE, keeping dir_up.
  - behind → MOVE, with dir_up inverted.
  - Otherwise stay in IDLE.
- MOVE:
  - A travel counter runs from 0 to TRAVEL_CYCLES-1.
  - On the terminal edge, cur_floor moves ±1 and arrive pulses in the next cycle.
  - Same edge, with priority top to bottom:
    - pending[new floor] → DOOR.
    - lock → LOCKED.
    - ahead of the new floor → MOVE (counter restarts).
    - Otherwise → IDLE.
  - hold is ignored in MOVE. lock is deferred until the current floor is reached.
- DOOR:
  - A dwell counter runs from 0 to DOOR_CYCLES-1.
  - hold=1 freezes the counter.
  - On expiry: lock → LOCKED, otherwise → IDLE.
- LOCKED: stays while lock=1; → IDLE on the first edge that samples lock=0. Calls are discarded throughout.
- cur_floor never leaves 0..FLOORS-1. Direction reversal at the end floors follows from the policy, since no pending floor exists beyond them.
- Simultaneous events:
  - A call for cur_floor arriving on the same edge that DOOR is entered or held is absorbed (not latched).
  - A call for a floor being passed is latched and served on a later sweep.

## Timing
- Calls are latched one edge after assertion (pending is registered). IDLE acts on the following edge.
  - Example: a call_req pulse sampled at edge N for the current floor gives door_open=1 after edge N+1.
- Each floor of travel takes exactly TRAVEL_CYCLES cycles in MOVE.
- With hold=0, door_open stays high for exactly DOOR_CYCLES cycles.
- IDLE→MOVE, MOVE→DOOR and DOOR→IDLE each take one edge; there are no bubble states.
- Reset asserted mid-operation immediately returns everything to reset values, including cur_floor=0. The car position is re-established by system software.

## Configuration
- ELEVATOR_SCHED_HOMING_EN defined:
  - An idle counter counts consecutive cycles in IDLE with pending=0, lock=0 and cur_floor≠0.
  - At IDLE_HOME_CYCLES the block sets dir_up=0 and enters MOVE toward floor 0.
  - At each arrival during homing, the normal MOVE rules apply, with floor 0 treated as a pending target until it is reached.
  - A new call arriving during homing is served per the SCAN policy; homing is abandoned.
- Not defined: the car stays at its last floor indefinitely when there are no calls, and the idle counter is not built.

## Test plan
Bench parameters: FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3, IDLE_HOME_CYCLES=10.
- Reset → cur_floor=0, dir_up=1, pending=0, moving=0, door_open=0, locked=0.
- call_req=4'b0100 for 1 cycle →
  - moving for 8 cycles.
  - arrive pulses at floor 1, then floor 2.
  - door_open for 3 cycles.
  - pending returns to 0, then IDLE.
- At floor 2 idle, call_req=4'b1001 in the same cycle →
  - dir_up stays 1; serves floor 3 first (door opens).
  - Then dir_up=0; travels 12 cycles to floor 0 and opens the door.
- While door_open, hold=1 for 10 cycles → door_open stays high throughout; closes 3 cycles after hold drops (with no further hold).
- lock=1 while in MOVE between floors 0 and 1 →
  - Arrives at floor 1 with no door open; locked=1; pending=0.
  - Calls ignored while locked.
  - lock=0 → IDLE on the next edge.
- Macro on: park at floor 2 with no calls → after 10 idle cycles, moving=1, dir_up=0, and the car reaches cur_floor=0. Macro off: the car remains at floor 2.
